pulse_timing_meter: RTL and testbench

//  Measures an external gate pulse against a trigger: cycles from trigger rising edge to pulse

---
 rtl/pulse_timing_meter_pkg.sv | 21 ++
 rtl/pulse_timing_meter_sync_edge_detect.sv | 39 +++
 rtl/pulse_timing_meter.sv | 126 ++++++++++++
 tb/tb_pulse_timing_meter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_timing_meter_pkg.sv
// Shared definitions for the pulse timing meter: FSM encodings and defaults.
package pulse_meter_pkg;

    // Default measurement limits
    localparam int DEFAULT_CNT_W   = 32;
    localparam int DEFAULT_TIMEOUT = 1_000_000;

    // 2-bit FSM state encodings
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_RISE = 2'd1;
    localparam logic [1:0] ST_WAIT_FALL = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE      = ST_IDLE,
        S_WAIT_RISE = ST_WAIT_RISE,
        S_WAIT_FALL = ST_WAIT_FALL,
        S_DONE      = ST_DONE
    } state_t;

endpackage

// File: rtl/pulse_timing_meter_sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input followed by registered
// single-cycle rise/fall event strobes. Every input that goes through this
// block sees the same latency, so relative timing between inputs is exact.
module sync_edge_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_in,
    output logic o_rise,
    output logic o_fall
);
    import pulse_meter_pkg::*;

    logic meta_reg;
    logic sync_reg;
    logic sync_d_reg;
    logic rise_reg;
    logic fall_reg;

    // Synchronize, keep one cycle of history, register the edge events
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta_reg   <= 1'b0;
            sync_reg   <= 1'b0;
            sync_d_reg <= 1'b0;
            rise_reg   <= 1'b0;
            fall_reg   <= 1'b0;
        end else begin
            meta_reg   <= i_in;
            sync_reg   <= meta_reg;
            sync_d_reg <= sync_reg;
            rise_reg   <= sync_reg & ~sync_d_reg;
            fall_reg   <= ~sync_reg & sync_d_reg;
        end
    end

    assign o_rise = rise_reg;
    assign o_fall = fall_reg;

endmodule

// File: rtl/pulse_timing_meter.sv
// Measures trigger-rise -> pulse-rise delay and pulse-rise -> pulse-fall width
// in clock cycles. One shared counter serves both phases; each phase is bounded
// by TIMEOUT so the counter can never wrap.
module pulse_timing_meter
    import pulse_meter_pkg::*;
#(
    parameter int CNT_W   = DEFAULT_CNT_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_trigger,
    input  logic             i_pulse,
    output logic [CNT_W-1:0] o_delay,
    output logic [CNT_W-1:0] o_width,
    output logic             o_valid,
    output logic             o_timeout,
    output logic             o_busy
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

    logic trig_rise;
    logic trig_fall_unused;
    logic pulse_rise;
    logic pulse_fall;

    state_t           state_reg;
    logic [CNT_W-1:0] counter_reg;
    logic [CNT_W-1:0] delay_latch_reg;
    logic [CNT_W-1:0] delay_out_reg;
    logic [CNT_W-1:0] width_out_reg;
    logic             valid_reg;
    logic             timeout_reg;
    logic             busy_reg;

    sync_edge_detect u_sync_trigger (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_in   (i_trigger),
        .o_rise (trig_rise),
        .o_fall (trig_fall_unused)
    );

    sync_edge_detect u_sync_pulse (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_in   (i_pulse),
        .o_rise (pulse_rise),
        .o_fall (pulse_fall)
    );

    // Measurement FSM: results are loaded on the terminating event so that
    // o_valid and the new values appear together during the DONE cycle.
    // Edge checks come before the limit check, so an edge on the limit cycle wins.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg       <= S_IDLE;
            counter_reg     <= '0;
            delay_latch_reg <= '0;
            delay_out_reg   <= '0;
            width_out_reg   <= '0;
            valid_reg       <= 1'b0;
            timeout_reg     <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (trig_rise) begin
                        counter_reg <= '0;
                        busy_reg    <= 1'b1;
                        state_reg   <= S_WAIT_RISE;
                    end
                end
                S_WAIT_RISE: begin
                    if (pulse_rise) begin
                        delay_latch_reg <= counter_reg + ONE;
                        counter_reg     <= '0;
                        state_reg       <= S_WAIT_FALL;
                    end else if (counter_reg == TIMEOUT_CNT) begin
                        delay_out_reg <= '0;
                        width_out_reg <= '0;
                        timeout_reg   <= 1'b1;
                        valid_reg     <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= S_DONE;
                    end else begin
                        counter_reg <= counter_reg + ONE;
                    end
                end
                S_WAIT_FALL: begin
                    if (pulse_fall) begin
                        delay_out_reg <= delay_latch_reg;
                        width_out_reg <= counter_reg + ONE;
                        timeout_reg   <= 1'b0;
                        valid_reg     <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= S_DONE;
                    end else if (counter_reg == TIMEOUT_CNT) begin
                        delay_out_reg <= delay_latch_reg;
                        width_out_reg <= '0;
                        timeout_reg   <= 1'b1;
                        valid_reg     <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= S_DONE;
                    end else begin
                        counter_reg <= counter_reg + ONE;
                    end
                end
                default: begin
                    // DONE: one cycle with o_valid high, triggers ignored
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign o_delay   = delay_out_reg;
    assign o_width   = width_out_reg;
    assign o_valid   = valid_reg;
    assign o_timeout = timeout_reg;
    assign o_busy    = busy_reg;

endmodule

// File: tb/tb_pulse_timing_meter.sv
// Directed bench for pulse_timing_meter with an expected-result queue that is
// drained by a monitor whenever o_valid strobes.
module tb_pulse_timing_meter;

    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 50;

    typedef struct {
        logic [CNT_W-1:0] d;
        logic [CNT_W-1:0] w;
        logic             to;
        string            tag;
    } exp_t;

    logic             clk;
    logic             i_rst;
    logic             i_trigger;
    logic             i_pulse;
    logic [CNT_W-1:0] o_delay;
    logic [CNT_W-1:0] o_width;
    logic             o_valid;
    logic             o_timeout;
    logic             o_busy;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;
    int   valid_count = 0;
    int   valid_cyc   = 0;
    int   busy_start  = 0;

    pulse_timing_meter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_trigger (i_trigger),
        .i_pulse   (i_pulse),
        .o_delay   (o_delay),
        .o_width   (o_width),
        .o_valid   (o_valid),
        .o_timeout (o_timeout),
        .o_busy    (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int d, input int w, input logic to, input string tag);
        exp_t e;
        e.d = CNT_W'(d);
        e.w = CNT_W'(w);
        e.to = to;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        chk({tag, "_done"}, CNT_W'(sb.size()), '0);
        sb.delete();
        tick(3);
    endtask

    // Plain trigger/pulse measurement: pulse rises d steps after trigger, high w steps
    task automatic measure(input int d, input int w);
        i_trigger = 1'b1;
        tick(d);
        i_pulse = 1'b1;
        tick(w);
        i_pulse = 1'b0;
        i_trigger = 1'b0;
    endtask

    // Monitor: compare every o_valid against the queue head; record timing
    initial begin
        logic busy_q;
        logic valid_q;
        exp_t e;
        busy_q = 1'b0;
        valid_q = 1'b0;
        forever begin
            @(negedge clk);
            if (o_busy && !busy_q) busy_start = cyc;
            if (o_valid) begin
                valid_count++;
                valid_cyc = cyc;
                chk("valid_not_back_to_back", {{(CNT_W-1){1'b0}}, valid_q}, '0);
                if (sb.size() == 0) begin
                    chk("unexpected_valid", CNT_W'(1), '0);
                end else begin
                    e = sb.pop_front();
                    chk({e.tag, "_delay"}, o_delay, e.d);
                    chk({e.tag, "_width"}, o_width, e.w);
                    chk({e.tag, "_timeout"}, {{(CNT_W-1){1'b0}}, o_timeout}, {{(CNT_W-1){1'b0}}, e.to});
                    $display("txn %s: delay=%0d width=%0d timeout=%0b", e.tag, o_delay, o_width, o_timeout);
                end
            end
            busy_q = o_busy;
            valid_q = o_valid;
        end
    end

    initial begin
        int vc;
        i_rst = 1'b1;
        i_trigger = 1'b0;
        i_pulse = 1'b0;
        tick(4);
        chk("rst_delay", o_delay, '0);
        chk("rst_width", o_width, '0);
        chk("rst_valid", {{(CNT_W-1){1'b0}}, o_valid}, '0);
        chk("rst_timeout", {{(CNT_W-1){1'b0}}, o_timeout}, '0);
        chk("rst_busy", {{(CNT_W-1){1'b0}}, o_busy}, '0);
        i_rst = 1'b0;
        tick(5);

        // 1: basic 10/5 measurement, busy during, valid latency D+W after busy rises
        push(10, 5, 1'b0, "basic");
        i_trigger = 1'b1;
        tick(6);
        chk("basic_busy_high", {{(CNT_W-1){1'b0}}, o_busy}, CNT_W'(1));
        tick(4);
        i_pulse = 1'b1;
        tick(5);
        i_pulse = 1'b0;
        i_trigger = 1'b0;
        wait_done("basic", 200);
        chk("basic_latency", CNT_W'(valid_cyc - busy_start), CNT_W'(15));
        chk("basic_busy_low", {{(CNT_W-1){1'b0}}, o_busy}, '0);
        tick(5);

        // 2: generator-style 20/8 repeated three times
        for (int r = 0; r < 3; r++) begin
            push(20, 8, 1'b0, "loop");
            measure(20, 8);
            wait_done("loop", 200);
            chk("loop_busy_between", {{(CNT_W-1){1'b0}}, o_busy}, '0);
            tick(5);
        end

        // 3: trigger with no pulse -> timeout, valid 51 cycles after start
        push(0, 0, 1'b1, "to_rise");
        i_trigger = 1'b1;
        wait_done("to_rise", 200);
        chk("to_rise_latency", CNT_W'(valid_cyc - busy_start), CNT_W'(TIMEOUT + 1));
        i_trigger = 1'b0;
        tick(5);

        // 4: pulse rises at 7 and stays high -> timeout in width phase
        push(7, 0, 1'b1, "to_fall");
        i_trigger = 1'b1;
        tick(7);
        i_pulse = 1'b1;
        wait_done("to_fall", 300);
        i_pulse = 1'b0;
        i_trigger = 1'b0;
        tick(5);

        // Boundary: pulse rise on the limit cycle wins over timeout
        push(TIMEOUT + 1, 3, 1'b0, "edge_wins");
        measure(TIMEOUT + 1, 3);
        wait_done("edge_wins", 200);
        tick(5);

        // 5a: second trigger edge during the width phase is ignored
        vc = valid_count;
        push(10, 6, 1'b0, "retrig");
        i_trigger = 1'b1;
        tick(10);
        i_pulse = 1'b1;
        tick(2);
        i_trigger = 1'b0;
        tick(2);
        i_trigger = 1'b1;
        tick(2);
        i_pulse = 1'b0;
        wait_done("retrig", 200);
        i_trigger = 1'b0;
        tick(10);
        chk("retrig_one_valid", CNT_W'(valid_count - vc), CNT_W'(1));

        // 5b: trigger and pulse rise together -> measures the next pulse rise
        push(7, 5, 1'b0, "same_cycle");
        i_trigger = 1'b1;
        i_pulse = 1'b1;
        tick(3);
        i_pulse = 1'b0;
        tick(4);
        i_pulse = 1'b1;
        tick(5);
        i_pulse = 1'b0;
        i_trigger = 1'b0;
        wait_done("same_cycle", 200);
        tick(5);

        // 6: reset during the width phase clears everything, no valid
        vc = valid_count;
        i_trigger = 1'b1;
        tick(5);
        i_pulse = 1'b1;
        tick(6);
        chk("mid_rst_busy_before", {{(CNT_W-1){1'b0}}, o_busy}, CNT_W'(1));
        i_rst = 1'b1;
        i_trigger = 1'b0;
        i_pulse = 1'b0;
        tick(1);
        chk("mid_rst_delay", o_delay, '0);
        chk("mid_rst_width", o_width, '0);
        chk("mid_rst_valid", {{(CNT_W-1){1'b0}}, o_valid}, '0);
        chk("mid_rst_timeout", {{(CNT_W-1){1'b0}}, o_timeout}, '0);
        chk("mid_rst_busy", {{(CNT_W-1){1'b0}}, o_busy}, '0);
        tick(1);
        i_rst = 1'b0;
        tick(10);
        chk("mid_rst_no_valid", CNT_W'(valid_count - vc), '0);

        push(12, 4, 1'b0, "after_rst");
        measure(12, 4);
        wait_done("after_rst", 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
